mp_add_sequencer: RTL and testbench
===================================

Name: mp_add_sequencer

Overview:
- Limb-serial multi-precision add controller that sits directly upstream and downstream of the 32-bit Brent-Kung adder.
- It accepts operand limbs least-significant first over a valid/ready stream and drives the adder's a/b/cin inputs.
- It captures the adder's sum/cout into a registered output stream, chaining the carry between limbs, so one 32-bit adder computes sums up to MAX_LIMBS*32 bits.

Parameters:
- WIDTH, 32, limb width; must equal the adder width.
- MAX_LIMBS, 8, maximum limbs per operation; must be ≥2.
- IDX_W, $clog2(MAX_LIMBS), width of the limb index.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  input limb valid.
- in_ready  out  1  input limb accepted when in_valid & in_ready.
- in_a  in  WIDTH  operand A limb.
- in_b  in  WIDTH  operand B limb.
- in_cin  in  1  carry-in; used on the first limb only.
- in_last  in  1  marks the most-significant limb.
- add_a  out  WIDTH  to adder a.
- add_b  out  WIDTH  to adder b.
- add_cin  out  1  to adder cin.
- add_sum  in  WIDTH  from adder sum.
- add_cout  in  1  from adder cout.
- out_valid  out  1  result limb valid.
- out_ready  in  1  downstream ready.
- out_sum  out  WIDTH  result limb.
- out_idx  out  IDX_W  limb index, 0 = least significant.
- out_last  out  1  final limb of the operation.
- out_cout  out  1  final carry-out; meaningful only when out_last=1, otherwise 0.
- out_err  out  1  limb-count overflow; meaningful only when out_last=1.

Behaviour:
- Reset: out_valid, out_sum, out_idx, out_last, out_cout and out_err = 0; carry_q = 0; idx_q = 0; state = FIRST.
- Adder drive is combinational:
  - add_a = in_a, add_b = in_b.
  - add_cin = in_cin in FIRST, carry_q in CHAIN.
- in_ready = !out_valid | out_ready. This is a single output register; full throughput is 1 limb/cycle when out_ready is held high.
- Accept = in_valid & in_ready. On accept, next edge:
  - out_valid = 1.
  - out_sum = add_sum.
  - out_idx = idx_q.
  - carry_q = add_cout.
- Latency: exactly 1 cycle from accept to out_valid.
- Output not taken (out_valid & !out_ready): all out_* hold stable; in_ready = 0.
- Output taken with no new accept: out_valid = 0.
- Simultaneous take and accept: the output register reloads, with no bubble.
- FSM transitions:
  - FIRST→FIRST on accept with in_last=1: single-limb operation; out_last=1, out_cout=add_cout, idx_q stays 0.
  - FIRST→CHAIN on accept with in_last=0: idx_q = 1.
  - CHAIN→CHAIN on accept with in_last=0 and idx_q<MAX_LIMBS-1: idx_q increments.
  - CHAIN→FIRST on accept with in_last=1: out_last=1, out_cout=add_cout, idx_q=0, carry_q=0.
  - CHAIN→FIRST on accept with idx_q==MAX_LIMBS-1 and in_last=0: forced termination; out_last=1, out_err=1, out_cout=add_cout. The next limb starts a new operation and uses in_cin.
- No accept: state, carry_q and idx_q hold.
- in_cin is ignored in CHAIN.
- Reset mid-operation: the partial operation and any pending output are discarded; the next accepted limb is treated as the first limb.
- Input stability: in_a/in_b/in_cin/in_last must stay stable while in_valid & !in_ready, per the standard valid/ready rule.

Optional Feature:
- Macro: MP_ADD_SUB_EN.
- When defined:
  - Extra input in_sub (1 bit), sampled on the first limb and latched for the whole operation as sub_q.
  - When sub active: add_b = ~in_b, and the first-limb add_cin = 1 (in_cin ignored).
  - out_cout in subtract mode is the inverted borrow: 1 = no borrow.
  - sub_q resets to 0 and clears on the last/forced-last limb.
- When undefined: no in_sub port, and add_b = in_b always.

Decomposition:
- Shared package mp_add_pkg holds:
  - LIMB_W = 32.
  - State enum {FIRST, CHAIN}.
  - A limb beat struct {data, idx, last, cout, err}.
- One natural sub-module: mp_out_reg, the single-entry valid/ready output register holding that struct.
- The FSM and carry/index logic stay in the top.

Test Plan:
- 1-limb: in_a=FFFFFFFF, in_b=1, in_cin=0, last=1 → next cycle out_sum=0, out_idx=0, out_last=1, out_cout=1.
- 4-limb, out_ready=1: A=limbs {FFFFFFFF,FFFFFFFF,FFFFFFFF,0}, B={1,0,0,0} → out_sum limbs {0,0,0,1}, idx 0..3, out_cout=0 on idx 3, one limb per cycle.
- Backpressure: out_ready=0 for 3 cycles mid-operation → in_ready=0, out_* stable, carry_q unchanged; release → remaining limbs correct, no loss or duplication.
- Overflow: MAX_LIMBS=8, 9 limbs with last only on the 9th → 8th output has out_last=1, out_err=1; the 9th is processed as a new first limb using in_cin.
- Reset mid-op: rst_n low after limb 2 of 4 → all outputs 0 immediately; a following 1-limb add of 5+7, cin=1 → out_sum=13, out_cout=0.
- MP_ADD_SUB_EN: 2-limb subtract, A={0,1}, B={1,0} → out_sum {FFFFFFFF,0}, out_cout=1; then A={0,0}, B={1,0} → {FFFFFFFF,FFFFFFFF}, out_cout=0 (borrow).

Source files
------------

// File: rtl/mp_add_pkg.sv
// -----------------------------------------------------------------------------
// mp_add_pkg
// Shared types for the limb-serial multi-precision add sequencer:
//   LIMB_W        limb width, equal to the downstream Brent-Kung adder width
//   MAX_LIMBS_DEF default maximum limbs per operation
//   IDX_W_DEF     limb index width for the default limb count
//   state_e       sequencer state (FIRST limb / CHAIN of carried limbs)
//   limb_beat_t   one result limb as held by the output register
// -----------------------------------------------------------------------------
package mp_add_pkg;

    localparam int unsigned LIMB_W        = 32;
    localparam int unsigned MAX_LIMBS_DEF = 8;
    localparam int unsigned IDX_W_DEF     = $clog2(MAX_LIMBS_DEF);

    typedef enum logic [0:0] {
        ST_FIRST = 1'b0,
        ST_CHAIN = 1'b1
    } state_e;

    // Sized for the default limb count; the top casts to its own widths.
    typedef struct packed {
        logic [LIMB_W-1:0]    data;
        logic [IDX_W_DEF-1:0] idx;
        logic                 last;
        logic                 cout;
        logic                 err;
    } limb_beat_t;

endpackage

// File: rtl/mp_add_sequencer_out_reg.sv
// -----------------------------------------------------------------------------
// mp_out_reg
// Single-entry valid/ready output register holding one result limb beat.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   load_i       capture beat_i this edge (caller guarantees room)
//   ready_i      downstream takes the held beat this edge
//   beat_i       beat to capture
//   valid_o      a beat is held
//   beat_o       held beat (stable while valid_o & !ready_i)
// -----------------------------------------------------------------------------
module mp_out_reg
    import mp_add_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic       ready_i,
    input  limb_beat_t beat_i,
    output logic       valid_o,
    output limb_beat_t beat_o
);

    logic       valid_q, valid_d;
    limb_beat_t beat_q, beat_d;

    // A load always wins; otherwise a take empties the register.
    always_comb begin
        valid_d = valid_q;
        beat_d  = beat_q;
        if (load_i) begin
            valid_d = 1'b1;
            beat_d  = beat_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
        end else begin
            valid_q <= valid_d;
            beat_q  <= beat_d;
        end
    end

    assign valid_o = valid_q;
    assign beat_o  = beat_q;

endmodule

// File: rtl/mp_add_sequencer.sv
// -----------------------------------------------------------------------------
// mp_add_sequencer
// Limb-serial multi-precision add controller wrapped around a 32-bit adder.
// Operand limbs arrive least-significant first; the carry is chained between
// limbs so a single adder produces sums of up to MAX_LIMBS*WIDTH bits.
// Optional feature macro: MP_ADD_SUB_EN (adds in_sub, two's-complement subtract).
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   in_valid/in_ready                  input limb handshake
//   in_a, in_b, in_cin, in_last        operand limbs, first-limb carry, MS limb
//   in_sub (MP_ADD_SUB_EN only)        subtract, sampled on the first limb
//   add_a, add_b, add_cin              combinational drive to the adder
//   add_sum, add_cout                  adder result
//   out_valid/out_ready                result limb handshake
//   out_sum, out_idx, out_last         result limb, index, final-limb flag
//   out_cout, out_err                  final carry, limb-count overflow
// -----------------------------------------------------------------------------
module mp_add_sequencer
    import mp_add_pkg::*;
#(
    parameter int unsigned WIDTH     = LIMB_W,
    parameter int unsigned MAX_LIMBS = MAX_LIMBS_DEF,
    parameter int unsigned IDX_W     = $clog2(MAX_LIMBS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef MP_ADD_SUB_EN
    input  logic             in_sub,
`endif
    input  logic             in_last,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_cout,
    output logic             out_err
);

    state_e           state_q, state_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             accept;
    logic             sub_eff;
    logic             end_of_op;
    limb_beat_t       beat_d, beat_q;

    // Subtract mode: taken live on the first limb, latched for the rest.
`ifdef MP_ADD_SUB_EN
    logic sub_q, sub_d;
    assign sub_eff = (state_q == ST_FIRST) ? in_sub : sub_q;
`else
    assign sub_eff = 1'b0;
`endif

    // Adder drive.
    assign add_a   = in_a;
    assign add_b   = sub_eff ? ~in_b : in_b;
    assign add_cin = (state_q == ST_FIRST) ? (sub_eff ? 1'b1 : in_cin) : carry_q;

    assign in_ready = !out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    // Operation ends on in_last or when the limb budget is exhausted.
    assign end_of_op = in_last |
                       ((state_q == ST_CHAIN) && (idx_q == IDX_W'(MAX_LIMBS - 1)));

    // Next-state, carry/index chaining and result beat formation.
    always_comb begin
        state_d     = state_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
`ifdef MP_ADD_SUB_EN
        sub_d       = sub_q;
`endif
        beat_d      = '0;
        beat_d.data = LIMB_W'(add_sum);
        beat_d.idx  = IDX_W_DEF'(idx_q);
        if (accept) begin
            if (end_of_op) begin
                beat_d.last = 1'b1;
                beat_d.cout = add_cout;
                beat_d.err  = !in_last;
                state_d     = ST_FIRST;
                carry_d     = 1'b0;
                idx_d       = '0;
`ifdef MP_ADD_SUB_EN
                sub_d       = 1'b0;
`endif
            end else begin
                state_d     = ST_CHAIN;
                carry_d     = add_cout;
                idx_d       = idx_q + IDX_W'(1);
`ifdef MP_ADD_SUB_EN
                sub_d       = sub_eff;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FIRST;
            carry_q <= 1'b0;
            idx_q   <= '0;
`ifdef MP_ADD_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
`ifdef MP_ADD_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    mp_out_reg u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (accept),
        .ready_i (out_ready),
        .beat_i  (beat_d),
        .valid_o (out_valid),
        .beat_o  (beat_q)
    );

    assign out_sum  = WIDTH'(beat_q.data);
    assign out_idx  = IDX_W'(beat_q.idx);
    assign out_last = beat_q.last;
    assign out_cout = beat_q.cout;
    assign out_err  = beat_q.err;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mp_add_sequencer
// Randomized and directed stimulus for mp_add_sequencer with an ideal adder
// attached. Expected limbs come from whole-operand wide arithmetic, split into
// MAX_LIMBS-sized operations where the limb budget forces termination.
// -----------------------------------------------------------------------------
module tb_mp_add_sequencer;

    localparam int unsigned W    = 32;
    localparam int unsigned MAXL = 8;
    localparam int unsigned IW   = $clog2(MAXL);

    typedef struct {
        logic [W-1:0] sum;
        int           idx;
        bit           last;
        bit           cout;
        bit           err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a, in_b;
    logic          in_cin, in_last, in_sub;
    logic [W-1:0]  add_a, add_b, add_sum;
    logic          add_cin, add_cout;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_sum;
    logic [IW-1:0] out_idx;
    logic          out_last, out_cout, out_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   rdy_mode = 0;     // 0: always ready, 1: random, 2: stalled
    bit   gaps     = 1'b0;
    bit   mon_en   = 1'b1;
    bit   hold_pending = 1'b0;
    logic [63:0] hold_val;

    exp_t          exp_q[$];
    logic [W-1:0]  op_a[$], op_b[$];
    bit            op_cin[$], op_sub[$];

    always #5 clk = ~clk;

    // Ideal adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    mp_add_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef MP_ADD_SUB_EN
        .in_sub    (in_sub),
`endif
        .in_last   (in_last),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .out_err   (out_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Downstream ready pattern.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 9) < 7);
            default: out_ready = 1'b0;
        endcase
    end

    // Output monitor: scoreboard on every take, stability while stalled.
    always @(negedge clk) begin
        exp_t e;
        logic [63:0] cur;
        if (!rst_n || !mon_en) begin
            hold_pending = 1'b0;
        end else begin
            cur = 64'({out_sum, out_idx, out_last, out_cout, out_err});
            chk("in_ready", 64'(in_ready), 64'(!out_valid | out_ready));
            if (hold_pending) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", cur, hold_val);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sum",  64'(out_sum),  64'(e.sum));
                    chk("idx",  64'(out_idx),  64'(e.idx));
                    chk("last", 64'(out_last), 64'(e.last));
                    chk("cout", 64'(out_cout), 64'(e.cout));
                    if (e.last) chk("err", 64'(out_err), 64'(e.err));
                end
            end
            hold_pending = out_valid && !out_ready;
            hold_val     = cur;
        end
    end

    // Reference: each operation is one wide addition; long streams split at MAXL.
    task automatic model_push();
        int n = op_a.size();
        int s = 0;
        while (s < n) begin
            int len;
            logic [MAXL*W:0] wa, wb, tot;
            bit sub, cin;
            exp_t e;
            len = (n - s > int'(MAXL)) ? int'(MAXL) : n - s;
            sub = op_sub[s];
            cin = sub ? 1'b1 : op_cin[s];
            wa = '0;
            wb = '0;
            for (int j = 0; j < len; j++) begin
                wa[j*W +: W] = op_a[s+j];
                wb[j*W +: W] = sub ? ~op_b[s+j] : op_b[s+j];
            end
            tot = wa + wb + (MAXL*W+1)'(cin);
            for (int j = 0; j < len; j++) begin
                e.sum  = tot[j*W +: W];
                e.idx  = j;
                e.last = (j == len - 1);
                e.cout = e.last ? tot[len*W] : 1'b0;
                e.err  = e.last && (s + len < n);
                exp_q.push_back(e);
            end
            s += len;
        end
    endtask

    task automatic clear_op();
        op_a.delete(); op_b.delete(); op_cin.delete(); op_sub.delete();
    endtask

    task automatic add_limb(input logic [W-1:0] a, input logic [W-1:0] b, input bit cin, input bit sub);
        op_a.push_back(a); op_b.push_back(b); op_cin.push_back(cin); op_sub.push_back(sub);
    endtask

    // Present one limb and hold it until accepted (called at posedge+1).
    task automatic send_limb(input int i, input bit last);
        int guard = 0;
        bit hs = 1'b0;
        in_valid = 1'b1;
        in_a     = op_a[i];
        in_b     = op_b[i];
        in_cin   = op_cin[i];
        in_last  = last;
`ifdef MP_ADD_SUB_EN
        in_sub   = op_sub[i];
`endif
        while (!hs && guard < 1000) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!hs) chk("accept_timeout", 64'd0, 64'd1);
        else     chk("latency_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic run_op(input bit with_model);
        int n = op_a.size();
        if (with_model) model_push();
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_limb(i, i == n - 1);
        end
    endtask

    task automatic drain();
        int guard = 0;
        rdy_mode = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [W-1:0] rnd_limb();
        return ($urandom_range(0, 3) == 0) ? {W{1'b1}} : W'($urandom);
    endfunction

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_cin   = 1'b0;
        in_last  = 1'b0;
        in_sub   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_sum",   64'(out_sum),   64'd0);
        chk("rst_idx",   64'(out_idx),   64'd0);
        chk("rst_last",  64'(out_last),  64'd0);
        chk("rst_cout",  64'(out_cout),  64'd0);
        chk("rst_err",   64'(out_err),   64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1-limb: FFFFFFFF + 1 wraps to 0 with carry out.
        clear_op();
        add_limb(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        run_op(1'b1);
        chk("d1_sum",  64'(out_sum),  64'd0);
        chk("d1_idx",  64'(out_idx),  64'd0);
        chk("d1_last", 64'(out_last), 64'd1);
        chk("d1_cout", 64'(out_cout), 64'd1);

        // 4-limb ripple through three all-ones limbs.
        clear_op();
        add_limb(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        add_limb(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
        add_limb(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
        add_limb(32'h0,         32'h0, 1'b0, 1'b0);
        run_op(1'b1);
        chk("d4_sum",  64'(out_sum),  64'd1);
        chk("d4_idx",  64'(out_idx),  64'd3);
        chk("d4_cout", 64'(out_cout), 64'd0);

        // Backpressure: 3 stalled cycles in the middle of a 6-limb operation.
        clear_op();
        for (int i = 0; i < 6; i++) add_limb(rnd_limb(), rnd_limb(), 1'($urandom), 1'b0);
        fork
            run_op(1'b1);
            begin
                repeat (2) @(posedge clk);
                rdy_mode = 2;
                repeat (3) @(posedge clk);
                rdy_mode = 0;
            end
        join
        drain();

        // Overflow: 9 limbs, last only on the 9th.
        clear_op();
        for (int i = 0; i < 9; i++) add_limb(rnd_limb(), rnd_limb(), 1'($urandom), 1'b0);
        op_cin[8] = 1'b1;
        run_op(1'b1);
        drain();

`ifdef MP_ADD_SUB_EN
        clear_op();
        add_limb(32'h0, 32'h1, 1'b0, 1'b1);
        add_limb(32'h1, 32'h0, 1'b0, 1'b1);
        run_op(1'b1);
        chk("s1_cout", 64'(out_cout), 64'd1);
        clear_op();
        add_limb(32'h0, 32'h1, 1'b0, 1'b1);
        add_limb(32'h0, 32'h0, 1'b0, 1'b1);
        run_op(1'b1);
        chk("s2_sum",  64'(out_sum),  64'hFFFF_FFFF);
        chk("s2_cout", 64'(out_cout), 64'd0);
        drain();
`endif

        // Reset mid-operation, then a fresh 1-limb add 5 + 7 + 1.
        mon_en = 1'b0;
        clear_op();
        for (int i = 0; i < 4; i++) add_limb(32'h0, 32'h0, 1'b0, 1'b0);
        send_limb(0, 1'b0);
        send_limb(1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 64'(out_valid), 64'd0);
        chk("mr_sum",   64'(out_sum),   64'd0);
        chk("mr_idx",   64'(out_idx),   64'd0);
        chk("mr_last",  64'(out_last),  64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        mon_en = 1'b1;
        clear_op();
        add_limb(32'd5, 32'd7, 1'b1, 1'b0);
        run_op(1'b1);
        chk("mr_add_sum",  64'(out_sum),  64'd13);
        chk("mr_add_idx",  64'(out_idx),  64'd0);
        chk("mr_add_cout", 64'(out_cout), 64'd0);
        drain();

        // Random operations with input gaps and random downstream stalls.
        gaps     = 1'b1;
        rdy_mode = 1;
        for (int k = 0; k < 150; k++) begin
            int n = $urandom_range(1, 12);
            bit sub = 1'b0;
`ifdef MP_ADD_SUB_EN
            sub = 1'($urandom);
`endif
            clear_op();
            for (int i = 0; i < n; i++) add_limb(rnd_limb(), rnd_limb(), 1'($urandom), sub);
            run_op(1'b1);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
